// File: rtl/servo_pkg.sv
// Shared timing defaults and channel state encoding for the servo pulse decoder.
package servo_pkg;

   localparam int DEF_MIN_HIGH_COUNT = 5;
   localparam int DEF_MAX_HIGH_COUNT = 30;
   localparam int DEF_MIN_LOW_COUNT  = 230;
   localparam int DEF_MAX_LOW_COUNT  = 250;
   localparam int DEF_THRESH_LO      = 13;
   localparam int DEF_THRESH_HI      = 17;
   localparam int DEF_GOOD_FRAMES    = 3;

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } chan_state_t;

endpackage

// File: rtl/servo_channel.sv
// One servo input: measures high time from edge strobes, validates frame timing,
// and derives a hysteresis level plus a loss-of-signal flag.
module servo_channel
   import servo_pkg::*;
#(
   parameter int   CNT_W          = 8,
   parameter int   MIN_HIGH_COUNT = DEF_MIN_HIGH_COUNT,
   parameter int   MAX_HIGH_COUNT = DEF_MAX_HIGH_COUNT,
   parameter int   MIN_LOW_COUNT  = DEF_MIN_LOW_COUNT,
   parameter int   MAX_LOW_COUNT  = DEF_MAX_LOW_COUNT,
   parameter int   THRESH_LO      = DEF_THRESH_LO,
   parameter int   THRESH_HI      = DEF_THRESH_HI,
   parameter int   GOOD_FRAMES    = DEF_GOOD_FRAMES,
   parameter logic FAILSAFE_VAL   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rise,
   input  logic             fall,
   output logic             log,
   output logic             rx_problem,
   output logic [CNT_W-1:0] width,
   output logic             width_valid
);

   localparam int GOOD_W = $clog2(GOOD_FRAMES + 1);

   localparam logic [CNT_W-1:0]  MIN_HI   = CNT_W'(MIN_HIGH_COUNT);
   localparam logic [CNT_W-1:0]  MAX_HI   = CNT_W'(MAX_HIGH_COUNT);
   localparam logic [CNT_W-1:0]  MIN_LO   = CNT_W'(MIN_LOW_COUNT);
   localparam logic [CNT_W-1:0]  MAX_LO   = CNT_W'(MAX_LOW_COUNT);
   localparam logic [CNT_W-1:0]  TH_LO    = CNT_W'(THRESH_LO);
   localparam logic [CNT_W-1:0]  TH_HI    = CNT_W'(THRESH_HI);
   localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(GOOD_FRAMES);

   chan_state_t       state;
   logic [CNT_W-1:0]  cnt;
   logic [GOOD_W-1:0] good;
   logic [GOOD_W-1:0] good_next;
   logic              fault;
   logic              start;
   logic              valid_fall;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   assign good_next = (good == GOOD_MAX) ? GOOD_MAX : good + 1'b1;

   always_comb begin
      fault      = 1'b0;
      start      = 1'b0;
      valid_fall = 1'b0;
      unique case (state)
         ST_WAIT: begin
            fault = rise & fall;
            start = rise & ~fall;
         end
         ST_HIGH: begin
            if (rise)
               fault = 1'b1;
            else if (fall)
               if (cnt > MIN_HI && cnt < MAX_HI) valid_fall = 1'b1;
               else                              fault      = 1'b1;
            else if (cnt > MAX_HI)
               fault = 1'b1;
         end
         ST_LOW: begin
            // A timeout outranks a late rise arriving on the same tick.
            if (fall || cnt > MAX_LO)
               fault = 1'b1;
            else if (rise)
               if (cnt > MIN_LO) start = 1'b1;
               else              fault = 1'b1;
         end
         default: fault = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_WAIT;
         cnt         <= '0;
         good        <= '0;
         rx_problem  <= 1'b1;
         log         <= FAILSAFE_VAL;
         width       <= '0;
         width_valid <= 1'b0;
      end else begin
         width_valid <= valid_fall;
         if (fault) begin
            state      <= ST_WAIT;
            cnt        <= '0;
            good       <= '0;
            rx_problem <= 1'b1;
            log        <= FAILSAFE_VAL;
         end else if (start) begin
            state <= ST_HIGH;
            cnt   <= '0;
         end else if (valid_fall) begin
            state <= ST_LOW;
            cnt   <= '0;
            width <= cnt;
            good  <= good_next;
            if (good_next == GOOD_MAX) rx_problem <= 1'b0;
            if (cnt > TH_HI)      log <= 1'b1;
            else if (cnt < TH_LO) log <= 1'b0;
         end else begin
            cnt <= sat_inc(cnt);
         end
      end
   end

endmodule

// File: rtl/servo_to_level.sv
// Multi-channel servo-to-level converter: one independent servo_channel per input.
module servo_to_level
   import servo_pkg::*;
#(
   parameter int   CHANNELS       = 4,
   parameter int   CNT_W          = 8,
   parameter int   MIN_HIGH_COUNT = DEF_MIN_HIGH_COUNT,
   parameter int   MAX_HIGH_COUNT = DEF_MAX_HIGH_COUNT,
   parameter int   MIN_LOW_COUNT  = DEF_MIN_LOW_COUNT,
   parameter int   MAX_LOW_COUNT  = DEF_MAX_LOW_COUNT,
   parameter int   THRESH_LO      = DEF_THRESH_LO,
   parameter int   THRESH_HI      = DEF_THRESH_HI,
   parameter int   GOOD_FRAMES    = DEF_GOOD_FRAMES,
   parameter logic FAILSAFE_VAL   = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       servo_rise,
   input  logic [CHANNELS-1:0]       servo_fall,
   output logic [CHANNELS-1:0]       log,
   output logic [CHANNELS-1:0]       rx_problem,
   output logic [CHANNELS*CNT_W-1:0] width,
   output logic [CHANNELS-1:0]       width_valid,
   output logic                      any_problem
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      servo_channel #(
         .CNT_W          (CNT_W),
         .MIN_HIGH_COUNT (MIN_HIGH_COUNT),
         .MAX_HIGH_COUNT (MAX_HIGH_COUNT),
         .MIN_LOW_COUNT  (MIN_LOW_COUNT),
         .MAX_LOW_COUNT  (MAX_LOW_COUNT),
         .THRESH_LO      (THRESH_LO),
         .THRESH_HI      (THRESH_HI),
         .GOOD_FRAMES    (GOOD_FRAMES),
         .FAILSAFE_VAL   (FAILSAFE_VAL)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .rise        (servo_rise[i]),
         .fall        (servo_fall[i]),
         .log         (log[i]),
         .rx_problem  (rx_problem[i]),
         .width       (width[i*CNT_W +: CNT_W]),
         .width_valid (width_valid[i])
      );
   end

   assign any_problem = |rx_problem;

endmodule

// File: tb/tb_servo_to_level.sv
// Directed bench for servo_to_level: a per-channel reference of lock/level state is
// checked every cycle, and width strobes are matched against a queued scoreboard.
module tb_servo_to_level;

   logic        clk;
   logic        rst;
   logic [3:0]  servo_rise;
   logic [3:0]  servo_fall;
   logic [3:0]  log;
   logic [3:0]  rx_problem;
   logic [31:0] width;
   logic [3:0]  width_valid;
   logic        any_problem;

   servo_to_level dut (
      .clk         (clk),
      .rst         (rst),
      .servo_rise  (servo_rise),
      .servo_fall  (servo_fall),
      .log         (log),
      .rx_problem  (rx_problem),
      .width       (width),
      .width_valid (width_valid),
      .any_problem (any_problem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int due;
      int w;
   } exp_t;

   exp_t       sb[4][$];
   int         n_assert = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic [3:0] prob_m;
   logic [3:0] log_m;
   int         good_m[4];
   int         width_m[4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic reset_model();
      prob_m = 4'b1111;
      log_m  = 4'b0000;
      for (int c = 0; c < 4; c++) begin
         good_m[c]  = 0;
         width_m[c] = 0;
         sb[c].delete();
      end
   endtask

   task automatic fault_model(input int c);
      prob_m[c] = 1'b1;
      log_m[c]  = 1'b0;
      good_m[c] = 0;
   endtask

   // One clock: drive at negedge, check every output 1 time unit after posedge.
   task automatic step(input logic [3:0] r, input logic [3:0] f, input logic rs);
      exp_t e;
      logic ewv;
      @(negedge clk);
      servo_rise = r;
      servo_fall = f;
      rst        = rs;
      @(posedge clk);
      #1;
      cyc++;
      for (int c = 0; c < 4; c++) begin
         ewv = (sb[c].size() > 0) && (sb[c][0].due == cyc);
         if (ewv) begin
            e = sb[c].pop_front();
            width_m[c] = e.w;
         end
         check($sformatf("width_valid[%0d]", c), 32'(width_valid[c]), 32'(ewv));
         check($sformatf("width[%0d]", c), 32'(width[c*8 +: 8]), 32'(width_m[c]));
         check($sformatf("rx_problem[%0d]", c), 32'(rx_problem[c]), 32'(prob_m[c]));
         check($sformatf("log[%0d]", c), 32'(log[c]), 32'(log_m[c]));
      end
      check("any_problem", 32'(any_problem), 32'(|prob_m));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'b0, 4'b0, 1'b0);
   endtask

   // Valid frame on channels m: fall arrives with cnt == h, next rise sees cnt == l.
   // Channels in 'both' get a coincident rise+fall on the rise tick instead.
   task automatic frame(input logic [3:0] m, input int h, input int l,
                        input logic [3:0] both = 4'b0);
      for (int c = 0; c < 4; c++)
         if (both[c]) fault_model(c);
      step(m | both, both, 1'b0);
      idle(h);
      for (int c = 0; c < 4; c++) begin
         if (m[c]) begin
            if (good_m[c] < 3) good_m[c]++;
            if (good_m[c] == 3) prob_m[c] = 1'b0;
            if (h > 17)      log_m[c] = 1'b1;
            else if (h < 13) log_m[c] = 1'b0;
            sb[c].push_back('{due: cyc + 1, w: h});
         end
      end
      step(4'b0, m, 1'b0);
      idle(l);
   endtask

   initial begin
      rst        = 1'b1;
      servo_rise = 4'b0;
      servo_fall = 4'b0;
      reset_model();
      step(4'b0, 4'b0, 1'b1);
      step(4'b0, 4'b0, 1'b1);
      idle(2);

      // Reset in the middle of a pulse discards it; the late fall lands in WAIT.
      step(4'b0001, 4'b0, 1'b0);
      idle(5);
      reset_model();
      step(4'b0, 4'b0, 1'b1);
      idle(8);
      step(4'b0, 4'b0001, 1'b0);
      idle(3);

      // Lock ch0 with three 11/239 frames.
      repeat (3) frame(4'b0001, 11, 239);

      // Hysteresis and range edges: 19 ->1, 15 hold, 6 ->0, 12 ->0, 29 ->1, 20 ->1.
      frame(4'b0001, 19, 239);
      frame(4'b0001, 15, 239);
      frame(4'b0001, 6, 239);
      frame(4'b0001, 12, 231);
      frame(4'b0001, 29, 239);
      frame(4'b0001, 20, 239);

      // Signal stops: low timeout when cnt reaches 251.
      idle(12);
      fault_model(0);
      idle(1);
      idle(3);

      // Relock, then an early rise (low of 100) faults; three more frames to clear.
      frame(4'b0001, 20, 239);
      frame(4'b0001, 20, 239);
      frame(4'b0001, 14, 100);
      fault_model(0);
      step(4'b0001, 4'b0, 1'b0);
      repeat (3) frame(4'b0001, 20, 239);

      // Over-long high: fault at cnt 31, later fall ignored.
      step(4'b0001, 4'b0, 1'b0);
      idle(31);
      fault_model(0);
      idle(1);
      idle(7);
      step(4'b0, 4'b0001, 1'b0);
      idle(3);

      // Lock all channels, then a coincident rise+fall on ch1 while others continue.
      repeat (3) frame(4'b1111, 20, 239);
      frame(4'b1101, 20, 239, 4'b0010);

      // LOW + fall on ch2.
      fault_model(2);
      step(4'b0, 4'b0100, 1'b0);
      // HIGH + rise on ch3.
      step(4'b1000, 4'b0, 1'b0);
      idle(4);
      fault_model(3);
      step(4'b1000, 4'b0, 1'b0);
      // Fall exactly at MAX_HIGH_COUNT on ch0 is out of range.
      step(4'b0001, 4'b0, 1'b0);
      idle(30);
      fault_model(0);
      step(4'b0, 4'b0001, 1'b0);
      idle(4);

      for (int c = 0; c < 4; c++)
         check($sformatf("scoreboard_left[%0d]", c), 32'(sb[c].size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/servo_to_level.md
SERVO_TO_LEVEL -- requirements
Module: servo_to_level

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent servo inputs.
REQ-002 Parameter CNT_W, default 8: counter and width-output bits per channel.
REQ-003 Parameters MIN_HIGH_COUNT 5, MAX_HIGH_COUNT 30, MIN_LOW_COUNT 230, MAX_LOW_COUNT 250, all in clk ticks.
REQ-004 Parameters THRESH_LO 13 and THRESH_HI 17: hysteresis band, with THRESH_LO <= THRESH_HI.
REQ-005 Parameter GOOD_FRAMES, default 3: consecutive valid pulses needed to clear rx_problem.
REQ-006 Parameter FAILSAFE_VAL, default 0: log level forced on fault.
REQ-007 clk  in  1  10 kHz tick clock; the single clock domain.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 servo_rise  in  CHANNELS  per-channel rising-edge strobe, one clk wide.
REQ-010 servo_fall  in  CHANNELS  per-channel falling-edge strobe, one clk wide.
REQ-011 log  out  CHANNELS  per-channel logic level, after hysteresis.
REQ-012 rx_problem  out  CHANNELS  per-channel loss or invalid-signal flag.
REQ-013 width  out  CHANNELS*CNT_W  last valid pulse width per channel; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-014 width_valid  out  CHANNELS  one-clk strobe per channel when width updates.
REQ-015 any_problem  out  1  combinational OR of rx_problem.

Function
REQ-016 Each channel SHALL run an independent FSM with states WAIT, HIGH and LOW, plus its own counter cnt and good-frame counter good.
REQ-017 cnt SHALL increment every clk and saturate at 2^CNT_W-1; it SHALL never wrap.
REQ-018 WAIT + rise: cnt<=0, go to HIGH, no low-period check. WAIT + fall: ignored.
REQ-019 HIGH + fall with MIN_HIGH_COUNT < cnt < MAX_HIGH_COUNT: width<=cnt, width_valid=1 on the next cycle, go to LOW, good<=min(good+1, GOOD_FRAMES).
REQ-020 On a valid fall, log<=1 if cnt > THRESH_HI and log<=0 if cnt < THRESH_LO; otherwise log holds.
REQ-021 rx_problem SHALL clear on the cycle after good reaches GOOD_FRAMES, and SHALL stay clear while valid frames continue.
REQ-022 HIGH + fall with width out of range SHALL be a fault.
REQ-023 HIGH with cnt > MAX_HIGH_COUNT and no fall SHALL be a fault.
REQ-024 HIGH + rise SHALL be a fault.
REQ-025 LOW + rise with cnt > MIN_LOW_COUNT: cnt<=0, go to HIGH.
REQ-026 LOW + rise with cnt <= MIN_LOW_COUNT SHALL be a fault.
REQ-027 LOW with cnt > MAX_LOW_COUNT SHALL be a fault.
REQ-028 LOW + fall SHALL be a fault.
REQ-029 Rise and fall in the same cycle SHALL be a fault in every state.
REQ-030 A fault SHALL set rx_problem<=1, log<=FAILSAFE_VAL, good<=0, cnt<=0, state<=WAIT; width SHALL hold its last valid value.
REQ-031 All outputs except any_problem SHALL be registered with one-clk latency from the sampled edge strobe.
REQ-032 Channels SHALL NOT interact; simultaneous events on different channels SHALL be processed in the same cycle.

Reset
REQ-033 While rst=1 at posedge clk: state=WAIT, cnt=0, good=0, rx_problem=all ones, log=FAILSAFE_VAL, width=0, width_valid=0.
REQ-034 rst asserted mid-pulse SHALL discard the measurement; the first post-reset rise SHALL start from WAIT.

Structure
REQ-035 Package servo_pkg SHALL hold the default timing constants and the channel-state enum (WAIT, HIGH, LOW).
REQ-036 Per-channel logic SHALL live in sub-module servo_channel.
REQ-037 servo_to_level SHALL instantiate servo_channel CHANNELS times via generate and form any_problem.

Verification
REQ-038 Reset, then 3 frames on ch0 of high 11 / low 239 -> rx_problem[0]=0 the cycle after the 3rd fall, log[0]=0, width=11.
REQ-039 Widths 19, 15, 12 after lock -> log: 1, hold 1, 0; width_valid pulses once per frame.
REQ-040 Input stops after lock -> rx_problem=1 and log=FAILSAFE_VAL at low cnt=251.
REQ-041 Rise 100 ticks after a fall -> fault, good=0; 3 further good frames are needed to clear.
REQ-042 High 40 ticks -> fault at cnt=31; the following fall is ignored in WAIT.
REQ-043 rise and fall coincident on ch1 while ch2 runs valid frames -> only rx_problem[1]=1; any_problem=1.
